// File: rtl/qua_lsp_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : qua_lsp_mem_arbiter_if
// Brief    : Request/grant and scratch-memory bus bundle for the LSP arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface qua_lsp_mem_arbiter_if;
    logic         testSel;
    logic [10:0]  testReadRequested;
    logic [10:0]  testWriteRequested;
    logic [31:0]  testWriteOut;
    logic         testWrite;
    logic [3:0]   req;
    logic [43:0]  readAddr;
    logic [43:0]  writeAddr;
    logic [127:0] writeOut;
    logic [3:0]   writeEn;
    logic [3:0]   grant;
    logic [10:0]  memReadAddr;
    logic [10:0]  memWriteAddr;
    logic [31:0]  memWriteOut;
    logic         memWriteEn;
    logic         busy;
    logic         timeout;

    modport master (
        output testSel, testReadRequested, testWriteRequested, testWriteOut, testWrite,
        output req, readAddr, writeAddr, writeOut, writeEn,
        input  grant, memReadAddr, memWriteAddr, memWriteOut, memWriteEn, busy, timeout
    );

    modport slave (
        input  testSel, testReadRequested, testWriteRequested, testWriteOut, testWrite,
        input  req, readAddr, writeAddr, writeOut, writeEn,
        output grant, memReadAddr, memWriteAddr, memWriteOut, memWriteEn, busy, timeout
    );
endinterface
`default_nettype wire

// File: rtl/qua_lsp_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : qua_lsp_mem_arbiter
// Brief    : Round-robin owner arbiter for the shared LSP scratch memory with a
//            test-port override. Optional hold timeout: QLSP_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module qua_lsp_mem_arbiter #(
    parameter int MAX_HOLD = 1024
) (
    input  wire logic           clk,
    input  wire logic           reset,
    qua_lsp_mem_arbiter_if.slave bus
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_OWNED = 1'b1;

    logic [0:0] r_state, w_state_nxt;
    logic [3:0] r_grant, w_grant_nxt;
    logic [1:0] r_owner, w_owner_nxt;
    logic [1:0] r_ptr,   w_ptr_nxt;
    logic       w_pick_vld;
    logic [1:0] w_pick_idx;
    logic       w_release;

`ifdef QLSP_ARB_TIMEOUT_EN
    localparam int c_CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [c_CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic               r_timeout,  w_timeout_nxt;
    logic               w_expired;

    assign w_expired   = (r_hold_cnt == c_CNT_W'(MAX_HOLD - 1));
    assign bus.timeout = r_timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_hold_cnt <= w_hold_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end
`else
    assign bus.timeout = 1'b0;
`endif

    // Walk from the highest offset down so the lowest offset above ptr wins.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (bus.req[r_ptr + 2'(i)]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = r_ptr + 2'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_grant <= 4'b0000;
            r_owner <= 2'd0;
            r_ptr   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_release   = 1'b0;
`ifdef QLSP_ARB_TIMEOUT_EN
        w_hold_cnt_nxt = r_hold_cnt;
        w_timeout_nxt  = 1'b0;
`endif
        case (r_state)
            c_ST_IDLE: begin
                if (!bus.testSel && w_pick_vld) begin
                    w_state_nxt = c_ST_OWNED;
                    w_grant_nxt = 4'b0001 << w_pick_idx;
                    w_owner_nxt = w_pick_idx;
`ifdef QLSP_ARB_TIMEOUT_EN
                    w_hold_cnt_nxt = '0;
`endif
                end
            end
            c_ST_OWNED: begin
                w_release = bus.testSel || !bus.req[r_owner];
`ifdef QLSP_ARB_TIMEOUT_EN
                // A voluntary release takes precedence, so timeout only flags forced ones.
                if (!w_release && w_expired) begin
                    w_release     = 1'b1;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + c_CNT_W'(1);
                end
`endif
                if (w_release) begin
                    w_state_nxt = c_ST_IDLE;
                    w_grant_nxt = 4'b0000;
                    w_ptr_nxt   = r_owner + 2'd1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_grant_nxt = 4'b0000;
            end
        endcase
    end

    always_comb begin
        bus.memReadAddr  = 11'd0;
        bus.memWriteAddr = 11'd0;
        bus.memWriteOut  = 32'd0;
        bus.memWriteEn   = 1'b0;
        if (bus.testSel) begin
            bus.memReadAddr  = bus.testReadRequested;
            bus.memWriteAddr = bus.testWriteRequested;
            bus.memWriteOut  = bus.testWriteOut;
            bus.memWriteEn   = bus.testWrite;
        end else if (r_state == c_ST_OWNED) begin
            bus.memReadAddr  = bus.readAddr[11*r_owner +: 11];
            bus.memWriteAddr = bus.writeAddr[11*r_owner +: 11];
            bus.memWriteOut  = bus.writeOut[32*r_owner +: 32];
            bus.memWriteEn   = bus.writeEn[r_owner];
        end
    end

    assign bus.grant = r_grant;
    assign bus.busy  = (|r_grant) | bus.testSel;

endmodule
`default_nettype wire

// File: tb/tb_qua_lsp_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_qua_lsp_mem_arbiter
// Brief    : Self-checking bench: vector table with scoreboard plus directed
//            override, reset and hold-timeout sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qua_lsp_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    qua_lsp_mem_arbiter_if bus();

    qua_lsp_mem_arbiter #(.MAX_HOLD(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] wen;
        logic       tsel;
        logic [3:0] exp_grant;
    } vec_t;

    typedef struct {
        int          row;
        logic [3:0]  grant;
        logic        wen;
        logic [10:0] raddr;
        logic [10:0] waddr;
        logic [31:0] wdata;
        logic        busy;
    } exp_t;

    vec_t vecs[16];
    exp_t sb[$];

    function automatic int owner_of(input logic [3:0] g);
        int k;
        k = 0;
        for (int i = 0; i < 4; i++) if (g[i]) k = i;
        return k;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        bus.req     = 4'b0000;
        bus.writeEn = 4'b0000;
        bus.testSel = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   k;

        vecs[0]  = '{4'b0001, 4'b0001, 1'b0, 4'b0001};
        vecs[1]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001};
        vecs[2]  = '{4'b0000, 4'b0001, 1'b0, 4'b0000};
        vecs[3]  = '{4'b1111, 4'b0010, 1'b0, 4'b0010};
        vecs[4]  = '{4'b1111, 4'b0100, 1'b0, 4'b0010};
        vecs[5]  = '{4'b1101, 4'b0000, 1'b0, 4'b0000};
        vecs[6]  = '{4'b1111, 4'b0100, 1'b0, 4'b0100};
        vecs[7]  = '{4'b1011, 4'b0000, 1'b0, 4'b0000};
        vecs[8]  = '{4'b1111, 4'b1000, 1'b0, 4'b1000};
        vecs[9]  = '{4'b0111, 4'b0000, 1'b0, 4'b0000};
        vecs[10] = '{4'b1111, 4'b1110, 1'b0, 4'b0001};
        vecs[11] = '{4'b1110, 4'b0000, 1'b0, 4'b0000};
        vecs[12] = '{4'b0100, 4'b0100, 1'b1, 4'b0000};
        vecs[13] = '{4'b0100, 4'b0100, 1'b0, 4'b0100};
        vecs[14] = '{4'b0100, 4'b0000, 1'b1, 4'b0000};
        vecs[15] = '{4'b0101, 4'b0001, 1'b0, 4'b0001};

        reset                  = 1'b1;
        bus.testSel            = 1'b0;
        bus.testReadRequested  = 11'd7;
        bus.testWriteRequested = 11'd448;
        bus.testWriteOut       = 32'h1234;
        bus.testWrite          = 1'b1;
        bus.req                = 4'b0000;
        bus.writeEn            = 4'b0000;
        bus.readAddr           = '0;
        bus.writeAddr          = '0;
        bus.writeOut           = '0;
        for (int i = 0; i < 4; i++) begin
            bus.readAddr[11*i +: 11]  = 11'(16 + i);
            bus.writeAddr[11*i +: 11] = 11'(288 + 32*i);
            bus.writeOut[32*i +: 32]  = 32'hA000_0000 + 32'(i);
        end

        @(negedge clk);
        check("reset_grant", 32'(bus.grant), 32'h0);
        check("reset_wen",   32'(bus.memWriteEn), 32'h0);
        check("reset_waddr", 32'(bus.memWriteAddr), 32'h0);
        check("reset_busy",  32'(bus.busy), 32'h0);
        check("reset_tmo",   32'(bus.timeout), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.req     = vecs[i].req;
            bus.writeEn = vecs[i].wen;
            bus.testSel = vecs[i].tsel;
            e.row   = i;
            e.grant = vecs[i].exp_grant;
            if (vecs[i].tsel) begin
                e.wen = 1'b1; e.raddr = 11'd7; e.waddr = 11'd448; e.wdata = 32'h1234; e.busy = 1'b1;
            end else if (vecs[i].exp_grant != 4'b0000) begin
                k = owner_of(vecs[i].exp_grant);
                e.wen   = vecs[i].wen[k];
                e.raddr = 11'(16 + k);
                e.waddr = 11'(288 + 32*k);
                e.wdata = 32'hA000_0000 + 32'(k);
                e.busy  = 1'b1;
            end else begin
                e.wen = 1'b0; e.raddr = 11'd0; e.waddr = 11'd0; e.wdata = 32'd0; e.busy = 1'b0;
            end
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d_grant", e.row), 32'(bus.grant), 32'(e.grant));
            check($sformatf("vec%0d_wen",   e.row), 32'(bus.memWriteEn), 32'(e.wen));
            check($sformatf("vec%0d_raddr", e.row), 32'(bus.memReadAddr), 32'(e.raddr));
            check($sformatf("vec%0d_waddr", e.row), 32'(bus.memWriteAddr), 32'(e.waddr));
            check($sformatf("vec%0d_wdata", e.row), 32'(bus.memWriteOut), e.wdata);
            check($sformatf("vec%0d_busy",  e.row), 32'(bus.busy), 32'(e.busy));
        end

        // Test-port takeover while requester 0 owns the memory.
        do_reset();
        bus.req = 4'b0011;
        @(posedge clk); #1;
        check("ovr_grant0", 32'(bus.grant), 32'b0001);
        @(negedge clk);
        bus.testSel = 1'b1;
        #1;
        check("ovr_waddr", 32'(bus.memWriteAddr), 32'd448);
        check("ovr_wdata", 32'(bus.memWriteOut), 32'h1234);
        check("ovr_wen",   32'(bus.memWriteEn), 32'h1);
        @(posedge clk); #1;
        check("ovr_revoke", 32'(bus.grant), 32'h0);
        check("ovr_busy",   32'(bus.busy), 32'h1);
        @(negedge clk);
        bus.testSel = 1'b0;
        @(posedge clk); #1;
        check("ovr_next_grant", 32'(bus.grant), 32'b0010);

        // Asynchronous reset during ownership by requester 2.
        do_reset();
        bus.req     = 4'b0100;
        bus.writeEn = 4'b0100;
        @(posedge clk); #1;
        check("rst_grant2", 32'(bus.grant), 32'b0100);
        check("rst_wen_before", 32'(bus.memWriteEn), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("rst_grant_async", 32'(bus.grant), 32'h0);
        check("rst_wen_async",   32'(bus.memWriteEn), 32'h0);
        @(negedge clk);
        reset       = 1'b0;
        bus.req     = 4'b0110;
        bus.writeEn = 4'b0000;
        @(posedge clk); #1;
        check("rst_ptr0_grant", 32'(bus.grant), 32'b0010);

        do_reset();
`ifdef QLSP_ARB_TIMEOUT_EN
        begin
            int         held;
            int         pulses;
            logic       seen_next;
            logic [3:0] g_at_pulse;
            held = 0; pulses = 0; seen_next = 1'b0; g_at_pulse = 4'hF;
            bus.req = 4'b0011;
            for (int c = 0; c < 30 && !seen_next; c++) begin
                @(posedge clk); #1;
                if (bus.grant == 4'b0001) held++;
                if (bus.timeout) begin
                    pulses++;
                    g_at_pulse = bus.grant;
                end
                if (bus.grant == 4'b0010) seen_next = 1'b1;
            end
            check("tmo_hold_cycles", 32'(held), 32'd8);
            check("tmo_pulses",      32'(pulses), 32'd1);
            check("tmo_idle_grant",  32'(g_at_pulse), 32'h0);
            check("tmo_next_owner",  32'(seen_next), 32'h1);
        end
`else
        begin
            int held;
            int tmo;
            held = 0; tmo = 0;
            bus.req = 4'b0001;
            for (int c = 0; c < 21; c++) begin
                @(posedge clk); #1;
                if (bus.grant == 4'b0001) held++;
                if (bus.timeout) tmo++;
            end
            check("nohold_cycles", 32'(held), 32'd21);
            check("nohold_tmo",    32'(tmo), 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qua_lsp_mem_arbiter.md
QUA_LSP_MEM_ARBITER -- requirements
Module: qua_lsp_mem_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 1024: maximum consecutive grant cycles per owner when the timeout feature is compiled in.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 testSel  input  1  bench override; test port owns scratch memory while high.
REQ-005 testReadRequested  input  11  test read address.
REQ-006 testWriteRequested  input  11  test write address.
REQ-007 testWriteOut  input  32  test write data.
REQ-008 testWrite  input  1  test write enable.
REQ-009 req  input  4  per-requester access request; bit k is requester k (0=Lsp_prev_extract, 1=Lsp_prev_update, 2=Lsp_expand, 3=Lsp_get_quant).
REQ-010 readAddr  input  44  packed read addresses; requester k at [11k+10:11k].
REQ-011 writeAddr  input  44  packed write addresses, same packing.
REQ-012 writeOut  input  128  packed write data; requester k at [32k+31:32k].
REQ-013 writeEn  input  4  per-requester write enable.
REQ-014 grant  output  4  registered one-hot-or-zero ownership.
REQ-015 memReadAddr  output  11  scratch memory read address.
REQ-016 memWriteAddr  output  11  scratch memory write address.
REQ-017 memWriteOut  output  32  scratch memory write data.
REQ-018 memWriteEn  output  1  scratch memory write enable.
REQ-019 busy  output  1  high when any grant is set or testSel is high.
REQ-020 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-021 FSM states SHALL be IDLE and OWNED; grant SHALL be nonzero only in OWNED.
REQ-022 IDLE with testSel=0 and req!=0: next edge SHALL grant the first set req bit searching from pointer ptr upward modulo 4, enter OWNED; grant visible one cycle after req sampled.
REQ-023 OWNED: grant SHALL hold while req[owner]=1; when req[owner]=0 is sampled, next edge SHALL clear grant, set ptr=owner+1 mod 4, enter IDLE.
REQ-024 At least one IDLE cycle SHALL separate consecutive grants; requests from non-owners during OWNED are held, not lost (level-sensitive).
REQ-025 testSel=1 SHALL combinationally route test ports to mem outputs (memReadAddr=testReadRequested, memWriteAddr=testWriteRequested, memWriteOut=testWriteOut, memWriteEn=testWrite).
REQ-026 testSel=1 sampled in OWNED SHALL revoke the grant at next edge, advance ptr as in REQ-023, enter IDLE; no grant SHALL issue while testSel=1.
REQ-027 testSel=0 with grant set: mem outputs SHALL be the owner's slice; memWriteEn=writeEn[owner]; non-owner writeEn SHALL be ignored.
REQ-028 testSel=0 and grant=0: all mem outputs SHALL be 0.
REQ-029 Memory read data is not routed by this block; all requesters share the memory's read bus.

Reset
REQ-030 reset high SHALL immediately force grant=0, ptr=0, state IDLE, timeout=0, hold counter=0; mem outputs then follow REQ-025/REQ-028.
REQ-031 reset asserted mid-ownership SHALL drop the grant without completing any pending write; the write in the reset cycle is whatever REQ-025/REQ-028 give.

Configuration
REQ-032 With QLSP_ARB_TIMEOUT_EN defined: a counter SHALL count OWNED cycles; after MAX_HOLD grant cycles the next edge SHALL clear grant, pulse timeout for one cycle, advance ptr, enter IDLE; counter clears on every entry to OWNED.
REQ-033 Without QLSP_ARB_TIMEOUT_EN: no counter SHALL exist, timeout SHALL be tied 0, ownership unbounded.

Verification
REQ-034 Reset, req=4'b0001 held -> grant=4'b0001 one cycle after req sampled; memWriteAddr tracks writeAddr[10:0] (e.g. 11'd288), memWriteEn follows writeEn[0].
REQ-035 req=4'b1111 held, each owner drops req 3 cycles after grant and reasserts -> grant sequence 0001,0010,0100,1000,0001 with one zero cycle between each.
REQ-036 Requester 1 owns; requester 2 writeEn=1, writeAddr=11'd320 -> memWriteEn=writeEn[1], memWriteAddr=requester 1 address.
REQ-037 testSel=1 during ownership by 0, testWriteRequested=11'd448, testWriteOut=32'h1234, testWrite=1 -> mem outputs equal test values same cycle, grant=0 next edge, busy=1; after testSel=0 with req=4'b0011, requester 1 granted.
REQ-038 QLSP_ARB_TIMEOUT_EN, MAX_HOLD=8, req=4'b0011 held -> owner 0 granted 8 cycles, timeout pulses once, idle cycle, then grant=4'b0010.
REQ-039 reset pulsed while grant=4'b0100 -> grant=0 immediately, memWriteEn=0; after release with req=4'b0110, requester 1 granted (ptr=0).
